// File: rtl/arb_mux.sv
// arb_mux: N-channel round-robin arbitrated valid/ready mux with a single registered output slot.
// Optional burst locking (grant held on one channel until its in_last beat) is enabled by defining ARB_MUX_BURST_LOCK_EN.
module arb_mux #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 64,
  parameter int SEL_WIDTH  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N-1:0]                   in_valid,
  input  logic [N-1:0][DATA_WIDTH-1:0]   in_data,
  input  logic [N-1:0]                   in_last,
  output logic [N-1:0]                   in_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [SEL_WIDTH-1:0]           out_sel,
  output logic                           out_last,
  input  logic                           out_ready
);

  logic [SEL_WIDTH-1:0] rr;
  logic [SEL_WIDTH-1:0] gsel;
  logic [SEL_WIDTH-1:0] rr_next;
  logic [N-1:0]         grant;
  logic                 found;
  logic                 load;
  logic                 xfer;
  int                   idx;

`ifdef ARB_MUX_BURST_LOCK_EN
  logic                 locked;
  logic [SEL_WIDTH-1:0] lock_ch;
`endif

  assign load     = !out_valid || out_ready;
  assign in_ready = load ? grant : '0;
  assign xfer     = |(in_valid & in_ready);
  assign rr_next  = (int'(gsel) == N - 1) ? '0 : gsel + 1'b1;

  // First valid requester at or above rr (wrapping) wins; a held lock overrides the search.
  always_comb begin
    grant = '0;
    gsel  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr) + k) % N;
      if (!found && in_valid[idx]) begin
        grant[idx] = 1'b1;
        gsel       = SEL_WIDTH'(idx);
        found      = 1'b1;
      end
    end
`ifdef ARB_MUX_BURST_LOCK_EN
    if (locked) begin
      grant          = '0;
      grant[lock_ch] = 1'b1;
      gsel           = lock_ch;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
      rr        <= '0;
`ifdef ARB_MUX_BURST_LOCK_EN
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gsel];
      out_sel   <= gsel;
      out_last  <= in_last[gsel];
`ifdef ARB_MUX_BURST_LOCK_EN
      // Mid-burst beats pin the grant and leave rr alone; the closing beat releases it.
      if (!in_last[gsel]) begin
        locked  <= 1'b1;
        lock_ch <= gsel;
      end else begin
        locked  <= 1'b0;
        rr      <= rr_next;
      end
`else
      rr        <= rr_next;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N-channel, valid/ready round-robin arbitrated multiplexer with a registered output stage. Each input channel presents a DATA_WIDTH word with a valid/ready handshake. A fair round-robin arbiter picks one requester per cycle and registers the winner's data, channel index and last flag into a single output slot. Used wherever several pipeline producers share one consumer, for example shared memory or writeback ports in the core.

## Interface
- N, 4: number of input channels, 1..32.
- DATA_WIDTH, 64: width of each data word.
- SEL_WIDTH, (N > 1) ? $clog2(N) : 1: width of the channel-index output.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  [N-1:0]  per-channel request.
- in_data  input  [N-1:0][DATA_WIDTH-1:0]  per-channel data.
- in_last  input  [N-1:0]  per-channel end-of-burst flag. Used only with the lock feature.
- in_ready  output  [N-1:0]  per-channel accept.
- out_valid  output  1  output slot holds a beat.
- out_data  output  DATA_WIDTH  registered data.
- out_sel  output  SEL_WIDTH  channel index of the registered beat.
- out_last  output  1  registered in_last of the beat.
- out_ready  input  1  consumer accept.

## Operation
- Load enable: `load = !out_valid || out_ready`.
- Grant logic:
  - The grant is one-hot and combinational.
  - Search starts at the round-robin pointer `rr` and proceeds upward with wrap-around. The first asserted in_valid wins.
  - If no channel is valid, there is no grant.
- `in_ready[i] = grant[i] & load`. At most one in_ready bit is high in any cycle.
  - in_ready never depends on in_valid of the same channel beyond grant selection.
- Input transfer on channel g: `in_valid[g] & in_ready[g]`. On the next edge:
  - out_data ← in_data[g], out_sel ← g, out_last ← in_last[g], out_valid ← 1.
  - rr ← (g+1) mod N.
- Output transfer: `out_valid & out_ready`.
  - With a simultaneous input transfer, the slot is overwritten and out_valid stays 1.
  - Without one, out_valid ← 0.
- Output stability: while `out_valid & !out_ready`, out_data, out_sel and out_last are held stable and all in_ready are 0.
- rr changes only on an input transfer. Non-granted requesters keep their priority order.
- N == 1:
  - The grant equals in_valid[0].
  - rr and out_sel are constant 0.

## Timing
- Latency is 1 cycle from an input transfer to out_valid.
- Throughput is 1 beat per cycle when out_ready is held high.
- Reset values:
  - out_valid=0, out_data=0, out_sel=0, out_last=0.
  - rr=0, lock state cleared.
  - in_ready reads 0 while out_valid=0 and no in_valid is asserted.
- Reset mid-operation: a beat held in the output slot is discarded (out_valid=0 the cycle after reset). The priority pointer returns to channel 0.
- in_valid may assert or deassert in any cycle. The block makes no stickiness assumption, and a withdrawn request loses its turn without changing rr.
- Simultaneous requests from all channels are granted in strict rotation: rr, rr+1, …, wrapping at N-1→0.

## Configuration
- Macro: ARB_MUX_BURST_LOCK_EN.
- Defined:
  - An input transfer from channel g with in_last[g]=0 sets locked=1 and lock_ch=g.
  - While locked, the grant is forced to lock_ch, even if lock_ch is not valid. All other in_ready bits are 0.
  - rr is not advanced by unlocked-burst beats.
  - A transfer from lock_ch with in_last=1 clears locked and sets rr ← (lock_ch+1) mod N.
  - Reset clears the lock.
- Undefined:
  - in_last is only passed through to out_last.
  - Every beat is re-arbitrated and rr advances after each transfer.

## Test plan
- Reset, then hold idle (all in_valid=0): out_valid=0, out_data=0, out_sel=0, in_ready=0 on every cycle.
- N=4, all in_valid=1 from reset, out_ready=1: out_sel sequence is 0,1,2,3,0,1 on consecutive cycles, starting 1 cycle after the first grant, with data matching each channel.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1. Required: out_data/out_sel frozen, all in_ready=0. Raising out_ready yields one output transfer plus a same-cycle reload, with no bubble.
- Only channel 2 valid, rr=0: channel 2 is granted and rr becomes 3. Then channels 0 and 3 valid together: channel 3 is granted first, then channel 0.
- Assert reset while out_valid=1 and channel 1 is mid-stream: out_valid=0 the next cycle. After release, with channels 0..3 valid, channel 0 is granted first.
- With ARB_MUX_BURST_LOCK_EN: channel 1 sends a 3-beat burst (last on beat 3) while channels 0 and 2 request. Required: out_sel=1,1,1, then 2, then 0. Without the macro, the same stimulus gives out_sel=1,2,0,1,1.
